// File: rtl/life_engine.sv
// Game-of-Life core: cell map, generation stepping, pointer edits and
// a registered RGB332 pixel colour for the VGA scan-out.
module life_engine #(
  parameter int         BLOCK_SIZE    = 20,
  parameter int         COUNT_X       = 32,
  parameter int         COUNT_Y       = 24,
  parameter int         SCREEN_W      = 640,
  parameter int         SCREEN_H      = 480,
  parameter logic [8:0] BIRTH_MASK    = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK  = 9'b000001100,
  parameter bit         WRAP          = 1'b1,
  parameter logic [7:0] COLOR_LIVE    = 8'b000_111_00,
  parameter logic [7:0] COLOR_EMPTY   = 8'b111_111_11,
  parameter logic [7:0] COLOR_POINTER = 8'b110_110_10,
  parameter logic [7:0] COLOR_BLACK   = 8'b000_000_00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run_enable,
  input  logic        tick,
  input  logic        step,
  input  logic        clear,
  input  logic        pointer_ready,
  input  logic [8:0]  pointer_delta_x,
  input  logic [8:0]  pointer_delta_y,
  input  logic        pointer_select,
  input  logic [9:0]  x_position,
  input  logic [8:0]  y_position,
  input  logic        inside_video,
  output logic [7:0]  color,
  output logic [15:0] generation,
  output logic        running
);

  localparam int N      = COUNT_X * COUNT_Y;
  localparam int GRID_W = COUNT_X * BLOCK_SIZE;
  localparam int GRID_H = COUNT_Y * BLOCK_SIZE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [N-1:0] map_q, map_d, life_d, edit_v;
  logic [9:0]  px_q, px_d;
  logic [8:0]  py_q, py_d;
  logic        sel_q;
  logic [15:0] gen_q;
  logic [7:0]  color_q, color_d;

  logic [3:0]  n;
  int          nx, ny;
  logic        inb;
  int          pxs, pys;
  int          pcx, pcy, qx, qy;
  logic        ptr_in, rise, upd;

  // Next generation for every cell at once.
  always_comb begin
    life_d = '0;
    n      = '0;
    nx     = 0;
    ny     = 0;
    inb    = 1'b0;
    for (int y = 0; y < COUNT_Y; y++) begin
      for (int x = 0; x < COUNT_X; x++) begin
        n = '0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            nx  = x + dx;
            ny  = y + dy;
            inb = (nx >= 0) && (nx < COUNT_X)
               && (ny >= 0) && (ny < COUNT_Y);
            if (WRAP) begin
              nx  = (nx + COUNT_X) % COUNT_X;
              ny  = (ny + COUNT_Y) % COUNT_Y;
              inb = 1'b1;
            end
            if (inb && (dx != 0 || dy != 0))
              n = n + 4'(map_q[ny*COUNT_X+nx]);
          end
        end
        life_d[y*COUNT_X+x] = map_q[y*COUNT_X+x]
                            ? SURVIVE_MASK[n] : BIRTH_MASK[n];
      end
    end
  end

  always_comb begin
    pxs = int'(px_q);
    pys = int'(py_q);
    if (pointer_ready) begin
      pxs = pxs + int'($signed(pointer_delta_x));
      pys = pys + int'($signed(pointer_delta_y));
    end
    if (pxs < 0) pxs = 0;
    else if (pxs > SCREEN_W - 1) pxs = SCREEN_W - 1;
    if (pys < 0) pys = 0;
    else if (pys > SCREEN_H - 1) pys = SCREEN_H - 1;
    px_d = 10'(pxs);
    py_d = 9'(pys);
  end

  always_comb begin
    pcx    = int'(px_q) / BLOCK_SIZE;
    pcy    = int'(py_q) / BLOCK_SIZE;
    ptr_in = (int'(px_q) < GRID_W) && (int'(py_q) < GRID_H);
    rise   = pointer_select & ~sel_q;
    edit_v = '0;
    if (rise && ptr_in)
      edit_v[pcy*COUNT_X+pcx] = 1'b1;
    upd   = (state_q == RUN) ? tick : step;
    map_d = (upd ? life_d : map_q) ^ edit_v;
  end

  always_comb begin
    qx      = int'(x_position) / BLOCK_SIZE;
    qy      = int'(y_position) / BLOCK_SIZE;
    color_d = 8'h00;
    if (inside_video) begin
      if (int'(x_position) >= GRID_W || int'(y_position) >= GRID_H)
        color_d = COLOR_BLACK;
      else if (map_q[qy*COUNT_X+qx])
        color_d = COLOR_LIVE;
      else if (ptr_in && qx == pcx && qy == pcy)
        color_d = COLOR_POINTER;
      else
        color_d = COLOR_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      map_q   <= '0;
      px_q    <= 10'(SCREEN_W / 2);
      py_q    <= 9'(SCREEN_H / 2);
      sel_q   <= 1'b0;
      gen_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= run_enable ? RUN : IDLE;
      sel_q   <= pointer_select;
      px_q    <= px_d;
      py_q    <= py_d;
      color_q <= color_d;
      // clear wins over both an edit and a generation step
      if (clear) begin
        map_q <= '0;
        gen_q <= '0;
      end else begin
        map_q <= map_d;
        if (upd) gen_q <= gen_q + 16'd1;
      end
    end
  end

  assign color      = color_q;
  assign generation = gen_q;
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: a wrapping 32x24 grid and a
// non-wrapping 3x5 grid driven from the same stimulus.
module tb_life_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run_enable = 1'b0, tick = 1'b0, step = 1'b0;
  logic        clear = 1'b0, pointer_ready = 1'b0;
  logic [8:0]  pointer_delta_x = '0, pointer_delta_y = '0;
  logic        pointer_select = 1'b0;
  logic [9:0]  x_position = '0;
  logic [8:0]  y_position = '0;
  logic        inside_video = 1'b0;
  logic [7:0]  color, color_nw;
  logic [15:0] generation, gen_nw;
  logic        running, run_nw;

  localparam logic [7:0] C_LIVE = 8'b000_111_00;
  localparam logic [7:0] C_EMPTY = 8'b111_111_11;
  localparam logic [7:0] C_PTR = 8'b110_110_10;

  life_engine u_dut (
    .clock(clock), .reset_n(reset_n), .run_enable(run_enable),
    .tick(tick), .step(step), .clear(clear),
    .pointer_ready(pointer_ready),
    .pointer_delta_x(pointer_delta_x),
    .pointer_delta_y(pointer_delta_y),
    .pointer_select(pointer_select),
    .x_position(x_position), .y_position(y_position),
    .inside_video(inside_video),
    .color(color), .generation(generation), .running(running)
  );

  life_engine #(.COUNT_X(3), .COUNT_Y(5), .WRAP(1'b0)) u_nw (
    .clock(clock), .reset_n(reset_n), .run_enable(run_enable),
    .tick(tick), .step(step), .clear(clear),
    .pointer_ready(pointer_ready),
    .pointer_delta_x(pointer_delta_x),
    .pointer_delta_y(pointer_delta_y),
    .pointer_select(pointer_select),
    .x_position(x_position), .y_position(y_position),
    .inside_video(inside_video),
    .color(color_nw), .generation(gen_nw), .running(run_nw)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  pxm = 320;
  int  pym = 240;

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL timeout: stimulus did not finish");
    $finish;
  end

  initial begin
    sb_t         e;
    logic [15:0] act;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          0: act = {8'h00, color};
          1: act = generation;
          2: act = {15'd0, running};
          default: act = {8'h00, color_nw};
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %0h want %0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push(int k, logic [15:0] e, string nm);
    sb.push_back('{k, e, nm});
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic logic [7:0] exp_col(bit live, int cx, int cy,
                                         int gx, int gy);
    if (live) return C_LIVE;
    if (pxm < gx*20 && pym < gy*20 && pxm/20 == cx && pym/20 == cy)
      return C_PTR;
    return C_EMPTY;
  endfunction

  task automatic nudge(int dx, int dy, int cnt);
    for (int i = 0; i < cnt; i++) begin
      pointer_delta_x = 9'(dx);
      pointer_delta_y = 9'(dy);
      pointer_ready = 1'b1;
      cycle();
      pointer_ready = 1'b0;
      pxm = clampi(pxm + dx, 0, 639);
      pym = clampi(pym + dy, 0, 479);
    end
  endtask

  task automatic move_to(int tx, int ty);
    for (int g = 0; g < 10 && (pxm != tx || pym != ty); g++)
      nudge(clampi(tx - pxm, -256, 255), clampi(ty - pym, -256, 255), 1);
  endtask

  task automatic press(int cx, int cy);
    move_to(cx*20 + 10, cy*20 + 10);
    pointer_select = 1'b1;
    cycle();
    pointer_select = 1'b0;
    cycle();
  endtask

  task automatic do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic probe(bit nw, int cx, int cy, bit live, string nm);
    x_position = 10'(cx*20 + 10);
    y_position = 9'(cy*20 + 10);
    inside_video = 1'b1;
    cycle();
    if (nw)
      push(3, {8'h00, exp_col(live, cx, cy, 3, 5)},
           $sformatf("%s_%0d_%0d", nm, cx, cy));
    else
      push(0, {8'h00, exp_col(live, cx, cy, 32, 24)},
           $sformatf("%s_%0d_%0d", nm, cx, cy));
  endtask

  function automatic bit glider(int x, int y, int ox, int oy);
    int rx = x - ox;
    int ry = y - oy;
    return (rx == 1 && ry == 0) || (rx == 2 && ry == 1)
        || (ry == 2 && rx >= 0 && rx <= 2);
  endfunction

  initial begin
    repeat (3) cycle();
    total++;
    if (generation !== 16'd0 || running !== 1'b0 || color !== 8'd0
        || gen_nw !== 16'd0 || run_nw !== 1'b0 || color_nw !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: gen=%0h run=%0b col=%0h",
               generation, running, color);
    end
    push(1, 16'd0, "rst_gen");
    push(2, 16'd0, "rst_running");
    push(0, 16'd0, "rst_color");
    reset_n = 1'b1;
    cycle();

    press(1, 0); press(2, 1); press(0, 2); press(1, 2); press(2, 2);
    repeat (4) do_step();
    push(1, 16'd4, "glider_gen");
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        probe(0, x, y, glider(x, y, 1, 1), "glider");

    repeat (384) do_step();
    push(1, 16'd388, "wrap_gen");
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++)
        probe(0, x, y, glider(x, y, 1, 1), "wrap");

    do_clear();
    push(1, 16'd0, "clear_gen");
    press(0, 2); press(1, 2); press(2, 2);
    do_step();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 3; x++)
        probe(1, x, y, (x == 1 && y >= 1 && y <= 3), "blk1");
    do_step();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 3; x++)
        probe(1, x, y, (y == 2), "blk2");

    do_clear();
    press(1, 0);
    x_position = 10'd25; y_position = 9'd5; inside_video = 1'b1;
    cycle();
    push(0, {8'h00, C_LIVE}, "pix25_5");
    inside_video = 1'b0;
    cycle();
    push(0, 16'd0, "pix_blank");
    x_position = 10'd100; y_position = 9'd10; inside_video = 1'b1;
    cycle();
    push(3, 16'd0, "nw_outside_black");

    do_clear();
    run_enable = 1'b1;
    cycle();
    push(2, 16'd1, "run_on");
    for (int i = 0; i < 40; i++) begin
      tick = (i % 10 == 9);
      step = (i % 10 == 4);
      cycle();
    end
    tick = 1'b0; step = 1'b0;
    push(1, 16'd4, "run_ticks");
    push(2, 16'd1, "run_still");
    run_enable = 1'b0;
    cycle();
    push(2, 16'd0, "run_off");
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    push(1, 16'd4, "idle_tick_ignored");
    do_step();
    push(1, 16'd5, "idle_step");

    nudge(-256, 0, 5);
    probe(0, 0, pym/20, 1'b0, "satlo");
    probe(0, 1, pym/20, 1'b0, "satlo");
    nudge(255, 0, 5);
    probe(0, 31, pym/20, 1'b0, "sathi");
    probe(0, 0, pym/20, 1'b0, "sathi");
    nudge(0, 255, 3);
    probe(0, 31, 23, 1'b0, "saty");

    do_clear();
    do_step();
    push(1, 16'd1, "pre_hold_gen");
    move_to(110, 110);
    pointer_select = 1'b1;
    repeat (100) cycle();
    pointer_select = 1'b0;
    cycle();
    probe(0, 5, 5, 1'b1, "hold");
    move_to(130, 130);
    clear = 1'b1; step = 1'b1; pointer_select = 1'b1;
    cycle();
    clear = 1'b0; step = 1'b0; pointer_select = 1'b0;
    cycle();
    probe(0, 5, 5, 1'b0, "clr");
    probe(0, 6, 6, 1'b0, "clr");
    push(1, 16'd0, "clr_gen");

    repeat (2) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL: %0d mismatches", bad);
    $finish;
  end

endmodule
